regfile_write_arbiter: RTL

//  Shares the single write port of a preloaded register file among REQS requesters.

---
 rtl/regfile_write_arbiter_pkg.sv | 14 +
 rtl/regfile_write_arbiter_rr_arbiter.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared state encoding and pointer helper for regfile_write_arbiter.
// The clear sweep state only exists when RFARB_CLEAR_EN is defined.
package regfile_write_arbiter_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int rr_next(input int id, input int reqs);
    return (id == reqs - 1) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after the
// pointer wins, scanning upward and wrapping REQS-1 -> 0.
module regfile_write_arbiter_rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int REQS = 2,
  parameter int PW   = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic [REQS-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [REQS-1:0] grant_o,
  output logic [PW-1:0]   winner_o,
  output logic [PW-1:0]   next_ptr_o,
  output logic            any_o
);

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int k = 0; k < REQS; k++) begin
      int pos;
      pos = int'(ptr_i) + k;
      if (pos >= REQS) pos = pos - REQS;
      if (!any_o && valid_i[PW'(pos)]) begin
        any_o             = 1'b1;
        grant_o[PW'(pos)] = 1'b1;
        winner_o          = PW'(pos);
      end
    end
    next_ptr_o = PW'(rr_next(int'(winner_o), REQS));
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one registered register-file write port.
// Define RFARB_CLEAR_EN to sweep every entry to CLEAR_VAL after reset.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int               REQS      = 2,
  parameter int               WIDTH     = 32,
  parameter int               N         = 5,
  parameter int               SIZE      = 32,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REQS-1:0]     req_valid,
  input  logic [REQS*N-1:0]   req_index,
  input  logic [REQS*WIDTH-1:0] req_data,
  output logic [REQS-1:0]     req_ready,
  output logic                wr_en,
  output logic [N-1:0]        wr_index,
  output logic [WIDTH-1:0]    wr_data,
  output logic                busy
);

  localparam int PW = (REQS > 1) ? $clog2(REQS) : 1;

  logic            run;
  logic            clearing;
  logic [N-1:0]    clr_idx;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   winner, next_ptr;
  logic [REQS-1:0] grant;
  logic            any_grant;

  logic            wr_en_q, wr_en_d;
  logic [N-1:0]    wr_index_q, wr_index_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

`ifdef RFARB_CLEAR_EN
  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The last sweep write is issued in the same cycle the FSM leaves CLEAR.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clearing = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearing = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == N'(SIZE - 1)) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign run     = (state_q == ST_RUN);
  assign busy    = (state_q == ST_CLEAR);
  assign clr_idx = cnt_q;
`else
  logic [WIDTH-1:0] unused_clear_val;

  assign unused_clear_val = CLEAR_VAL;
  assign run      = 1'b1;
  assign clearing = 1'b0;
  assign busy     = 1'b0;
  assign clr_idx  = '0;
`endif

  regfile_write_arbiter_rr_arbiter #(
    .REQS (REQS),
    .PW   (PW)
  ) u_rr (
    .valid_i    (req_valid & {REQS{run}}),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .winner_o   (winner),
    .next_ptr_o (next_ptr),
    .any_o      (any_grant)
  );

  assign req_ready = grant;

  always_comb begin
    wr_en_d    = 1'b0;
    wr_index_d = wr_index_q;
    wr_data_d  = wr_data_q;
    ptr_d      = ptr_q;
    if (clearing) begin
      wr_en_d    = 1'b1;
      wr_index_d = clr_idx;
      wr_data_d  = CLEAR_VAL;
    end else if (any_grant) begin
      wr_en_d = 1'b1;
      ptr_d   = next_ptr;
      for (int i = 0; i < REQS; i++) begin
        if (grant[i]) begin
          wr_index_d = req_index[i*N +: N];
          wr_data_d  = req_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Reset drops any write that was accepted but not yet presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_index_q <= wr_index_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_index = wr_index_q;
  assign wr_data  = wr_data_q;

endmodule
